// File: rtl/mat_loader_ctrl.sv
// Matrix loader / sequencer between the HPS command port and the matrix ALU.
// The HPS writes operand elements into MatA/MatB and then starts the ALU. The
// controller waits for the ALU to finish, with a watchdog as a backstop,
// captures the 25-element result, and then streams it back one element per
// read strobe.
module mat_loader_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [31:0]  wr_data,
    input  logic         rd_en,
    output logic [31:0]  rd_data,
    output logic         rd_valid,
    output logic         busy,
    output logic         res_ready,
    output logic         err,
    output logic [199:0] MatA,
    output logic [199:0] MatB,
    output logic [7:0]   Esc,
    output logic [1:0]   Op,
    output logic         en,
    input  logic [199:0] Mat0,
    input  logic         Overflow,
    input  logic         done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        CAPTURE = 2'd2,
        RESULT  = 2'd3
    } state_t;

    localparam logic [1:0] OPC_LOAD  = 2'b00;
    localparam logic [1:0] OPC_START = 2'b01;
    localparam logic [1:0] OPC_CLEAR = 2'b10;
    localparam logic [4:0] LAST_IDX  = 5'd24;
    // The watchdog holds the number of RUN cycles already spent. On the 255th
    // cycle without done the run is abandoned.
    localparam logic [7:0] WD_LAST   = 8'd254;

    state_t         state_q, state_d;
    logic [7:0]     wd_q, wd_d;
    logic [199:0]   mat_a_q, mat_b_q;
    logic [7:0]     esc_q;
    logic [1:0]     op_q;
    logic           err_q;
    logic [199:0]   buf_q;
    logic           ovf_q;
    logic [4:0]     rd_ptr_q;
    logic [31:0]    rd_data_q;
    logic           rd_valid_q;

    // Command decode
    logic [1:0]     cmd_opc;
    logic           cmd_tgt;
    logic [4:0]     cmd_idx;
    logic [7:0]     cmd_val;
    logic           is_load, is_start, is_clear, is_bad;

    assign cmd_opc  = wr_data[31:30];
    assign cmd_tgt  = wr_data[29];
    assign cmd_idx  = wr_data[28:24];
    assign cmd_val  = wr_data[7:0];
    assign is_load  = wr_en && (cmd_opc == OPC_LOAD);
    assign is_start = wr_en && (cmd_opc == OPC_START);
    assign is_clear = wr_en && (cmd_opc == OPC_CLEAR);
    assign is_bad   = wr_en && (cmd_opc == 2'b11);

    // Strobes computed by the FSM and consumed by the datapath
    logic           load_ok, start_ok, capture, rd_fire, err_set;

    // FSM state register and watchdog
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
        end
    end

    // Next-state and per-cycle action decode; CLEAR overrides everything
    always_comb begin
        state_d  = state_q;
        wd_d     = wd_q;
        load_ok  = 1'b0;
        start_ok = 1'b0;
        capture  = 1'b0;
        rd_fire  = 1'b0;
        err_set  = is_bad;
        case (state_q)
            IDLE: begin
                if (is_load) begin
                    if (cmd_idx > LAST_IDX) err_set = 1'b1;
                    else                    load_ok = 1'b1;
                end
                if (is_start) begin
                    start_ok = 1'b1;
                    wd_d     = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (is_load || is_start) err_set = 1'b1;
                if (done) begin
                    wd_d    = '0;
                    state_d = CAPTURE;
                end else if (wd_q == WD_LAST) begin
                    wd_d    = '0;
                    err_set = 1'b1;
                    state_d = IDLE;
                end else begin
                    wd_d    = wd_q + 8'd1;
                end
            end
            CAPTURE: begin
                if (is_load || is_start) err_set = 1'b1;
                capture = !is_clear;
                state_d = RESULT;
            end
            RESULT: begin
                if (is_load || is_start) err_set = 1'b1;
                if (rd_en && !is_clear) begin
                    rd_fire = 1'b1;
                    // The final element ends the session; no wrap to 0.
                    if (rd_ptr_q == LAST_IDX) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (is_clear) begin
            state_d = IDLE;
            wd_d    = '0;
        end
    end

    // Operand matrices, scalar and opcode. Writes are only accepted in IDLE,
    // so the operands stay frozen while the ALU works.
    always_ff @(posedge clk) begin
        if (rst || is_clear) begin
            mat_a_q <= '0;
            mat_b_q <= '0;
            esc_q   <= '0;
            op_q    <= '0;
        end else begin
            if (load_ok) begin
                if (cmd_tgt) mat_b_q[{cmd_idx, 3'b000} +: 8] <= cmd_val;
                else         mat_a_q[{cmd_idx, 3'b000} +: 8] <= cmd_val;
            end
            if (start_ok) begin
                esc_q <= wr_data[15:8];
                op_q  <= wr_data[1:0];
            end
        end
    end

    // Sticky error flag
    always_ff @(posedge clk) begin
        if (rst || is_clear) err_q <= 1'b0;
        else if (err_set)    err_q <= 1'b1;
    end

    // Result buffer capture and read-out pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q    <= '0;
            ovf_q    <= 1'b0;
            rd_ptr_q <= '0;
        end else if (capture) begin
            buf_q    <= Mat0;
            ovf_q    <= Overflow;
            rd_ptr_q <= '0;
        end else if (rd_fire) begin
            rd_ptr_q <= rd_ptr_q + 5'd1;
        end
    end

    // Read response: one word per accepted read, rd_data holds between reads
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_fire;
            if (rd_fire)
                rd_data_q <= {ovf_q, 2'b00, rd_ptr_q, 16'h0000,
                              buf_q[{rd_ptr_q, 3'b000} +: 8]};
        end
    end

    assign MatA      = mat_a_q;
    assign MatB      = mat_b_q;
    assign Esc       = esc_q;
    assign Op        = op_q;
    assign err       = err_q;
    assign en        = (state_q == RUN);
    assign busy      = (state_q == RUN) || (state_q == CAPTURE);
    assign res_ready = (state_q == RESULT);
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;

endmodule

// File: doc/mat_loader_ctrl.md
MAT_LOADER_CTRL -- requirements
Module: mat_loader_ctrl

Interface
REQ-001 SHALL: clk  in  1  single system clock; all state updates on rising edge.
REQ-002 SHALL: rst  in  1  synchronous reset, active-high.
REQ-003 SHALL: wr_en  in  1  HPS command-write strobe; one command per cycle high.
REQ-004 SHALL: wr_data  in  32  command word (format REQ-014..016).
REQ-005 SHALL: rd_en  in  1  HPS result-read strobe.
REQ-006 SHALL: rd_data  out  32  result word: [31]=captured overflow, [28:24]=element index, [7:0]=element value, all other bits 0.
REQ-007 SHALL: rd_valid  out  1  one-cycle pulse qualifying rd_data.
REQ-008 SHALL: busy  out  1  high in RUN and CAPTURE.
REQ-009 SHALL: res_ready  out  1  high in RESULT.
REQ-010 SHALL: err  out  1  sticky error flag; cleared only by rst or CLEAR.
REQ-011 SHALL: MatA, MatB  out  200 each  operand matrices to the ALU stage; element i (0..24, i=row*5+col) at bits [8i+7:8i].
REQ-012 SHALL: Esc  out  8, Op  out  2, en  out  1  scalar, opcode and enable to the ALU stage.
REQ-013 SHALL: Mat0  in  200, Overflow  in  1, done  in  1  ALU result, overflow and completion (Mat0/Overflow are registered by the ALU on the edge where en and done are both high).

Function
REQ-014 SHALL: wr_data[31:30]=00 LOAD: [29]=target (0=MatA, 1=MatB), [28:24]=index, [7:0]=value; written into the target element on the cycle after wr_en.
REQ-015 SHALL: wr_data[31:30]=01 START: [15:8] latched to Esc, [1:0] latched to Op, FSM goes IDLE->RUN.
REQ-016 SHALL: wr_data[31:30]=10 CLEAR: MatA, MatB, Esc, Op <= 0, err <= 0, FSM -> IDLE, from any state; opcode 11 is ignored and sets err.
REQ-017 SHALL: LOAD with index > 24 leaves the matrices unchanged and sets err.
REQ-018 SHALL: FSM states IDLE, RUN, CAPTURE, RESULT; reset state IDLE.
REQ-019 SHALL: IDLE accepts LOAD, START, CLEAR.
REQ-020 SHALL: RUN drives en=1 (en=0 in every other state); on the first cycle done=1 is sampled, go to CAPTURE.
REQ-021 SHALL: RUN carries an 8-bit watchdog starting at 0 on entry; if it reaches 255 without done, en drops, err sets, FSM -> IDLE.
REQ-022 SHALL: CAPTURE lasts exactly one cycle, latching Mat0 and Overflow into an internal 200-bit result buffer plus overflow flag, then -> RESULT; rd_ptr <= 0.
REQ-023 SHALL: in RESULT, each rd_en returns buffer element rd_ptr on rd_data with rd_valid high on the following cycle, then rd_ptr increments.
REQ-024 SHALL: the read returning index 24 moves the FSM to IDLE in the same cycle rd_valid is asserted; no wrap-around to index 0.
REQ-025 SHALL: rd_en outside RESULT produces no rd_valid and leaves rd_data unchanged.
REQ-026 SHALL: LOAD/START in RUN, CAPTURE or RESULT is dropped and sets err; CLEAR always executes.
REQ-027 SHALL: with wr_en (CLEAR) and rd_en in the same RESULT cycle, CLEAR wins: no rd_valid, FSM -> IDLE.
REQ-028 SHALL: MatA, MatB, Esc, Op remain stable from START until the FSM leaves CAPTURE.

Reset
REQ-029 SHALL: on rst=1 at a clock edge: FSM=IDLE, MatA=MatB=0, Esc=0, Op=0, en=0, busy=0, res_ready=0, err=0, rd_valid=0, rd_data=0, rd_ptr=0, watchdog=0, result buffer=0.
REQ-030 SHALL: rst mid-RUN drops en on the next edge, and the ALU result of that run is never captured.

Verification
REQ-031 SHALL: LOAD A[0]=3, B[0]=4, START Op=00 with done pulsed 3 cycles later and Mat0[7:0]=7 -> busy 1 then 0, res_ready=1, first read rd_data=0x00000007.
REQ-032 SHALL: in RESULT, 25 back-to-back reads -> indices 0..24 in order, IDLE after the 25th, a 26th rd_en gives no rd_valid.
REQ-033 SHALL: LOAD index 25 -> matrices unchanged, err=1; then CLEAR -> err=0, MatA=0.
REQ-034 SHALL: START with done held 0 -> en high for 255 cycles, then en=0, err=1, IDLE.
REQ-035 SHALL: Overflow=1 captured with Op=11 -> every rd_data word has bit31=1; a LOAD during RUN sets err and leaves MatA unchanged.
REQ-036 SHALL: rst asserted during RUN -> next cycle en=0, all outputs at reset values.
